// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier issue sequencer: default sizes and FSM states.
package mul_pkg;

    // Operand/product width matching the multiplier datapath.
    localparam int W_DEF = 16;

    // Cycles allowed in BUSY before an operation is declared hung.
    // Must exceed the worst-case repeated-addition count (2^W) plus margin.
    localparam int TIMEOUT_DEF = 70000;

    // Issue sequence: pop -> start pulse -> load A -> load B -> wait -> hand result out.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        LDA    = 3'd2,
        LDB    = 3'd3,
        BUSY   = 3'd4,
        RESULT = 3'd5
    } state_t;

endpackage

// File: rtl/mul_op_fifo.sv
// Operand-pair FIFO: DEPTH entries of DW bits, head visible combinationally.
module mul_op_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]   wr_ptr_reg;
    logic [AW:0]   rd_ptr_reg;
    logic [DW-1:0] mem [DEPTH];

    // Pointer update; a reset discards everything queued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push && !full)
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (pop && !empty)
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
        end
    end

    // Storage write; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr_reg[AW-1:0]] <= din;
    end

    // The issue FSM inspects the head in the same cycle it pops it.
    assign dout  = mem[rd_ptr_reg[AW-1:0]];
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

endmodule

// File: rtl/mul_issue_seq.sv
// Issue stage for the repeated-addition multiplier: queues operand pairs,
// sequences start/A/B onto the shared data bus, collects the product and
// returns it on a valid/ready result port, with zero-operand bypass and a
// hang timeout.
module mul_issue_seq
    import mul_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         op_valid,
    output logic         op_ready,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    output logic         mul_start,
    output logic [W-1:0] mul_data,
    input  logic         mul_done,
    input  logic [W-1:0] mul_y,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_p,
    output logic         res_err
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE  = 1;

    state_t         state_reg, state_next;
    logic [W-1:0]   a_reg, b_reg;
    logic [W-1:0]   res_p_reg;
    logic           res_err_reg;
    logic [CW-1:0]  cnt_reg, cnt_next;

    logic           fifo_full, fifo_empty, fifo_pop;
    logic [2*W-1:0] fifo_head;
    logic [W-1:0]   head_a, head_b;
    logic           head_trivial;
    logic           timed_out;

    mul_op_fifo #(
        .DW    (2 * W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (op_valid),
        .pop   (fifo_pop),
        .din   ({op_a, op_b}),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head_a       = fifo_head[2*W-1:W];
    assign head_b       = fifo_head[W-1:0];
    // A zero operand gives a zero product; skip the multiplier entirely.
    assign head_trivial = (head_a == '0) || (head_b == '0);
    assign timed_out    = (cnt_reg == CNT_LAST);

    assign op_ready  = !fifo_full;
    assign res_valid = (state_reg == RESULT);
    assign res_p     = res_p_reg;
    assign res_err   = res_err_reg;
    assign mul_start = (state_reg == START);

    // Next-state, pop request and BUSY cycle counter.
    always_comb begin
        state_next = state_reg;
        fifo_pop   = 1'b0;
        cnt_next   = '0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty && !res_valid) begin
                    fifo_pop   = 1'b1;
                    state_next = head_trivial ? RESULT : START;
                end
            end
            START:  state_next = LDA;
            LDA:    state_next = LDB;
            LDB:    state_next = BUSY;
            BUSY: begin
                if (mul_done || timed_out)
                    state_next = RESULT;
                else
                    cnt_next = cnt_reg + CNT_ONE;
            end
            RESULT: begin
                if (res_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Drive the shared multiplier bus: A during start/load-A, B from load-B onwards.
    always_comb begin
        mul_data = '0;
        case (state_reg)
            START, LDA: mul_data = a_reg;
            LDB, BUSY:  mul_data = b_reg;
            default:    mul_data = '0;
        endcase
    end

    // State, operand latch, timeout counter and result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            cnt_reg     <= '0;
            res_p_reg   <= '0;
            res_err_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (fifo_pop) begin
                a_reg <= head_a;
                b_reg <= head_b;
                if (head_trivial) begin
                    res_p_reg   <= '0;
                    res_err_reg <= 1'b0;
                end
            end
            if (state_reg == BUSY) begin
                if (mul_done) begin
                    res_p_reg   <= mul_y;
                    res_err_reg <= 1'b0;
                end else if (timed_out) begin
                    res_p_reg   <= '0;
                    res_err_reg <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mul_issue_seq.sv
// Directed bench for mul_issue_seq with a behavioural repeated-addition multiplier stand-in.
module tb_mul_issue_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic        op_ready;
    logic [15:0] op_a, op_b;
    logic        mul_start;
    logic [15:0] mul_data;
    logic        mul_done;
    logic [15:0] mul_y;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_p;
    logic        res_err;

    logic        model_done;
    logic        stray_done;
    logic        hang;
    int          done_delay;

    int compared   = 0;
    int mismatched = 0;
    int starts     = 0;
    logic [16:0] res_q[$];
    logic [16:0] exp_q[$];

    assign mul_done = model_done | stray_done;

    always #5 clk = ~clk;

    mul_issue_seq #(.W(16), .DEPTH(4), .TIMEOUT(100)) dut (
        .clk       (clk),
        .rst       (rst),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .mul_start (mul_start),
        .mul_data  (mul_data),
        .mul_done  (mul_done),
        .mul_y     (mul_y),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_p     (res_p),
        .res_err   (res_err)
    );

    // Multiplier stand-in: samples A and B on the load cycles, raises done after done_delay BUSY cycles.
    int          ph;
    int          dly;
    logic [15:0] ma, mb;
    always @(negedge clk) begin
        if (rst) begin
            ph         <= 0;
            model_done <= 1'b0;
            mul_y      <= '0;
        end else begin
            model_done <= 1'b0;
            if (mul_start) begin
                ph <= 1;
            end else begin
                case (ph)
                    1: begin ma <= mul_data; ph <= 2; end
                    2: begin mb <= mul_data; dly <= done_delay; ph <= 3; end
                    3: begin
                        if (!hang) begin
                            if (dly <= 1) begin
                                model_done <= 1'b1;
                                mul_y      <= ma * mb;
                                ph         <= 0;
                            end else begin
                                dly <= dly - 1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Record accepted results and count start pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (res_valid && res_ready)
                res_q.push_back({res_err, res_p});
            if (mul_start)
                starts++;
        end
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Called just after a rising edge; holds op_valid until the pair is taken.
    task automatic push(input logic [15:0] a, input logic [15:0] b);
        int  n = 0;
        logic r = 1'b0;
        op_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        while (n < 400) begin
            @(negedge clk);
            r = op_ready;
            @(posedge clk);
            #1;
            n++;
            if (r) break;
        end
        op_valid = 1'b0;
        check($sformatf("push_accept_%0d_%0d", a, b), {31'd0, r}, 32'd1);
    endtask

    task automatic wait_res(input string tag);
        int n = 0;
        while (res_valid !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, res_valid}, 32'd1);
    endtask

    task automatic check_q(input string tag);
        int n = 0;
        while (res_q.size() < exp_q.size() && n < 800) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_count"}, res_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < res_q.size())
                check($sformatf("%s_res%0d", tag, i), {15'd0, res_q[i]}, {15'd0, exp_q[i]});
        end
        res_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int   s0;
        logic any_valid;
        rst        = 1'b1;
        op_valid   = 1'b0;
        op_a       = '0;
        op_b       = '0;
        res_ready  = 1'b1;
        stray_done = 1'b0;
        hang       = 1'b0;
        done_delay = 6;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_op_ready",  {31'd0, op_ready},  32'd1);
        check("rst_mul_start", {31'd0, mul_start}, 32'd0);
        check("rst_mul_data",  {16'd0, mul_data},  32'd0);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_res_p",     {16'd0, res_p},     32'd0);
        check("rst_res_err",   {31'd0, res_err},   32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: single operation 17*5
        push(16'd17, 16'd5);
        @(negedge clk);
        check("t1_idle_start", {31'd0, mul_start}, 32'd0);
        @(negedge clk);
        check("t1_start",      {31'd0, mul_start}, 32'd1);
        check("t1_start_data", {16'd0, mul_data},  32'd17);
        @(negedge clk);
        check("t1_lda_start",  {31'd0, mul_start}, 32'd0);
        check("t1_lda_data",   {16'd0, mul_data},  32'd17);
        @(negedge clk);
        check("t1_ldb_data",   {16'd0, mul_data},  32'd5);
        @(negedge clk);
        check("t1_busy_data",  {16'd0, mul_data},  32'd5);
        check("t1_busy_valid", {31'd0, res_valid}, 32'd0);
        wait_res("t1_valid");
        check("t1_res_p",   {16'd0, res_p},   32'd85);
        check("t1_res_err", {31'd0, res_err}, 32'd0);
        exp_q.push_back({1'b0, 16'd85});
        check_q("t1");

        // done while idle must be ignored
        @(posedge clk); #1;
        stray_done = 1'b1;
        @(posedge clk); #1;
        stray_done = 1'b0;
        @(negedge clk);
        check("stray_done_valid", {31'd0, res_valid}, 32'd0);

        // 3: zero-operand bypass
        s0 = starts;
        @(posedge clk); #1;
        push(16'd0, 16'd9);
        @(negedge clk);
        check("t3a_pop_cycle", {31'd0, res_valid}, 32'd0);
        @(negedge clk);
        check("t3a_valid", {31'd0, res_valid}, 32'd1);
        check("t3a_res_p", {16'd0, res_p},     32'd0);
        @(posedge clk); #1;
        push(16'd9, 16'd0);
        @(negedge clk);
        check("t3b_pop_cycle", {31'd0, res_valid}, 32'd0);
        @(negedge clk);
        check("t3b_valid", {31'd0, res_valid}, 32'd1);
        check("t3b_res_p", {16'd0, res_p},     32'd0);
        check("t3_no_start", starts, s0);
        exp_q.push_back({1'b0, 16'd0});
        exp_q.push_back({1'b0, 16'd0});
        check_q("t3");

        // 2: fill the FIFO behind a held result, then drain in order
        @(posedge clk); #1;
        res_ready = 1'b0;
        push(16'd2, 16'd3);
        wait_res("t2_first_valid");
        @(posedge clk); #1;
        push(16'd10, 16'd10);
        push(16'd7, 16'd9);
        push(16'd255, 16'd3);
        push(16'd300, 16'd300);
        check("t2_full_ready", {31'd0, op_ready}, 32'd0);
        res_ready = 1'b1;
        push(16'd11, 16'd13);
        exp_q.push_back({1'b0, 16'd6});
        exp_q.push_back({1'b0, 16'd100});
        exp_q.push_back({1'b0, 16'd63});
        exp_q.push_back({1'b0, 16'd765});
        exp_q.push_back({1'b0, 16'd24464});
        exp_q.push_back({1'b0, 16'd143});
        check_q("t2");

        // 4: result held 20 cycles, second op must not issue
        @(posedge clk); #1;
        res_ready = 1'b0;
        push(16'd3, 16'd4);
        push(16'd6, 16'd7);
        wait_res("t4_valid");
        s0 = starts;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("t4_hold_valid_%0d", i), {31'd0, res_valid}, 32'd1);
            check($sformatf("t4_hold_p_%0d", i),     {16'd0, res_p},     32'd12);
        end
        check("t4_no_second_start", starts, s0);
        @(posedge clk); #1;
        res_ready = 1'b1;
        exp_q.push_back({1'b0, 16'd12});
        exp_q.push_back({1'b0, 16'd42});
        check_q("t4");

        // 5: hung multiplier, timeout abort at BUSY cycle 100
        @(posedge clk); #1;
        res_ready = 1'b0;
        hang      = 1'b1;
        push(16'd4, 16'd5);
        push(16'd6, 16'd6);
        begin
            int n = 0;
            logic seen = 1'b0;
            while (!seen && n < 50) begin
                @(negedge clk);
                seen = mul_start;
                n++;
            end
            check("t5_start_seen", {31'd0, seen}, 32'd1);
        end
        repeat (102) @(negedge clk);
        check("t5_busy_cycle100_valid", {31'd0, res_valid}, 32'd0);
        @(negedge clk);
        check("t5_timeout_valid", {31'd0, res_valid}, 32'd1);
        check("t5_timeout_err",   {31'd0, res_err},   32'd1);
        check("t5_timeout_p",     {16'd0, res_p},     32'd0);
        @(posedge clk); #1;
        hang      = 1'b0;
        res_ready = 1'b1;
        exp_q.push_back({1'b1, 16'd0});
        exp_q.push_back({1'b0, 16'd36});
        check_q("t5");

        // 6: reset during BUSY with 3 pairs queued
        @(posedge clk); #1;
        hang = 1'b1;
        push(16'd1, 16'd2);
        push(16'd3, 16'd3);
        push(16'd5, 16'd5);
        push(16'd7, 16'd7);
        repeat (3) @(negedge clk);
        check("t6_busy_data", {16'd0, mul_data}, 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_op_ready",  {31'd0, op_ready},  32'd1);
        check("t6_rst_mul_start", {31'd0, mul_start}, 32'd0);
        check("t6_rst_mul_data",  {16'd0, mul_data},  32'd0);
        check("t6_rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("t6_rst_res_p",     {16'd0, res_p},     32'd0);
        check("t6_rst_res_err",   {31'd0, res_err},   32'd0);
        @(posedge clk); #1;
        rst  = 1'b0;
        hang = 1'b0;
        s0   = starts;
        any_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (res_valid) any_valid = 1'b1;
        end
        check("t6_no_stale_valid", {31'd0, any_valid}, 32'd0);
        check("t6_no_stale_start", starts, s0);
        check("t6_no_stale_result", res_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
